mul_pipe_hs: RTL and testbench

Parametrised pipelined integer multiplier with valid/ready handshakes on input and output, per-operation signed/unsigned mode, full-width product, overflow flag and tag pass-through. Next-generation multiplier DUT sitting between the AFU state machine and the CCI write path. It replaces fixed-cycle waiting with backpressure-aware streaming at one operation per cycle.

---
 rtl/mul_pipe_hs_if.sv | 28 ++
 rtl/mul_pipe_hs.sv | 98 +++++++++
 tb/tb_mul_pipe_hs.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_pipe_hs_if.sv
// Handshake bundle for mul_pipe_hs: operation offer on the input side,
// full-width product plus overflow and tag on the output side.
interface mul_pipe_hs_if #(
  parameter int DATA_LEN = 32,
  parameter int TAG_LEN  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_signed;
  logic [DATA_LEN-1:0]   in_a;
  logic [DATA_LEN-1:0]   in_b;
  logic [TAG_LEN-1:0]    in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_LEN-1:0] out_result;
  logic                  out_overflow;
  logic [TAG_LEN-1:0]    out_tag;

  modport slave (
    input  in_valid, in_signed, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_tag
  );

  modport master (
    output in_valid, in_signed, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_tag
  );
endinterface

// File: rtl/mul_pipe_hs.sv
// Pipelined signed/unsigned multiplier with elastic valid/ready stages.
// The product is formed at accept time and then carried through the stages.
module mul_pipe_hs #(
  parameter int DATA_LEN       = 32,
  parameter int PIPELINE_STAGE = 2,
  parameter int TAG_LEN        = 4
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      flush,
  mul_pipe_hs_if.slave                              bus,
  output logic [$clog2(PIPELINE_STAGE+1)-1:0]       occupancy
);
  localparam int P     = PIPELINE_STAGE;
  localparam int W     = 2 * DATA_LEN;
  localparam int OCC_W = $clog2(PIPELINE_STAGE + 1);

  logic [P-1:0]         vld_q;
  logic [P-1:0]         ovf_q;
  logic [W-1:0]         prod_q [P];
  logic [TAG_LEN-1:0]   tag_q  [P];
  logic [P-1:0]         move;
  logic                 accept;
  logic [W-1:0]         ext_a, ext_b, prod;
  logic                 ovf;

  always_comb begin
    ext_a = bus.in_signed ? {{DATA_LEN{bus.in_a[DATA_LEN-1]}}, bus.in_a}
                          : {{DATA_LEN{1'b0}}, bus.in_a};
    ext_b = bus.in_signed ? {{DATA_LEN{bus.in_b[DATA_LEN-1]}}, bus.in_b}
                          : {{DATA_LEN{1'b0}}, bus.in_b};
    prod  = ext_a * ext_b;
    // Signed fits only if the top DATA_LEN+1 bits are a pure sign extension.
    if (bus.in_signed)
      ovf = !((&prod[W-1:DATA_LEN-1]) || !(|prod[W-1:DATA_LEN-1]));
    else
      ovf = |prod[W-1:DATA_LEN];
  end

  // Stage k can advance when any stage at or beyond it is empty, or the sink takes.
  always_comb begin
    logic full;
    move = '0;
    for (int k = 0; k < P; k++) begin
      full = 1'b1;
      for (int j = k; j < P; j++)
        full = full & vld_q[j];
      move[k] = bus.out_ready || !full;
    end
  end

  assign bus.in_ready = !flush && move[0];
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      ovf_q <= '0;
      for (int k = 0; k < P; k++) begin
        prod_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      if (flush) begin
        vld_q <= '0;
      end else begin
        if (move[0])
          vld_q[0] <= accept;
        for (int k = 1; k < P; k++)
          if (move[k])
            vld_q[k] <= vld_q[k-1];
      end
      if (move[0] && accept) begin
        prod_q[0] <= prod;
        ovf_q[0]  <= ovf;
        tag_q[0]  <= bus.in_tag;
      end
      for (int k = 1; k < P; k++) begin
        if (move[k] && vld_q[k-1]) begin
          prod_q[k] <= prod_q[k-1];
          ovf_q[k]  <= ovf_q[k-1];
          tag_q[k]  <= tag_q[k-1];
        end
      end
    end
  end

  assign bus.out_valid    = vld_q[P-1];
  assign bus.out_result   = prod_q[P-1];
  assign bus.out_overflow = ovf_q[P-1];
  assign bus.out_tag      = tag_q[P-1];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < P; k++)
      occupancy = occupancy + OCC_W'(vld_q[k]);
  end
endmodule

// File: tb/tb_mul_pipe_hs.sv
// Scoreboard bench for mul_pipe_hs: directed corner products, backpressure,
// flush, mid-flight reset and a random stream with random out_ready.
module tb_mul_pipe_hs;
  localparam int DL = 32;
  localparam int P  = 2;
  localparam int TL = 4;

  typedef struct {
    logic [63:0]   res;
    logic          ovf;
    logic [TL-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic [$clog2(P+1)-1:0] occupancy;

  mul_pipe_hs_if #(.DATA_LEN(DL), .TAG_LEN(TL)) bus ();

  mul_pipe_hs #(.DATA_LEN(DL), .PIPELINE_STAGE(P), .TAG_LEN(TL)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int pops  = 0;
  exp_t sb[$];
  logic [63:0]   last_res;
  logic          last_ovf;
  logic [TL-1:0] last_tag;
  logic          hold = 1'b0;
  logic [63:0]   h_res;
  logic [TL-1:0] h_tag;
  logic          h_ovf;
  logic          done = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                 input logic [TL-1:0] t);
    exp_t e;
    longint sp;
    longint unsigned up;
    if (s) begin
      sp    = longint'($signed(a)) * longint'($signed(b));
      e.res = sp;
      e.ovf = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
    end else begin
      up    = {32'h0, a} * {32'h0, b};
      e.res = up;
      e.ovf = up > 64'h0000_0000_FFFF_FFFF;
    end
    e.tag = t;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset || flush) begin
      sb.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_res", bus.out_result, h_res);
        chk("hold_ovf", 64'(bus.out_overflow), 64'(h_ovf));
        chk("hold_tag", 64'(bus.out_tag), 64'(h_tag));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious", 64'(bus.out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("result", bus.out_result, e.res);
          chk("overflow", 64'(bus.out_overflow), 64'(e.ovf));
          chk("tag", 64'(bus.out_tag), 64'(e.tag));
          last_res = bus.out_result;
          last_ovf = bus.out_overflow;
          last_tag = bus.out_tag;
          pops++;
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back(model(bus.in_signed, bus.in_a, bus.in_b, bus.in_tag));
      hold  = bus.out_valid && !bus.out_ready;
      h_res = bus.out_result;
      h_ovf = bus.out_overflow;
      h_tag = bus.out_tag;
    end
  end

  task automatic drive_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [TL-1:0] t);
    bus.in_valid  = 1'b1;
    bus.in_signed = s;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = t;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic [TL-1:0] t);
    logic acc = 1'b0;
    drive_op(s, a, b, t);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      cyc++;
    end
    #1;
  endtask

  task automatic directed(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [TL-1:0] t, input logic [63:0] r, input logic o);
    int cyc;
    @(posedge clk);
    #1;
    send(s, a, b, t);
    wait_out(cyc);
    chk("latency", 64'(cyc), 64'(P - 1));
    chk("dir_result", last_res, r);
    chk("dir_ovf", 64'(last_ovf), 64'(o));
    chk("dir_tag", 64'(last_tag), 64'(t));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int pops0;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_result", bus.out_result, 64'd0);
    chk("rst_out_ovf", 64'(bus.out_overflow), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    directed(1'b0, 32'd7, 32'd6, 4'd3, 64'd42, 1'b0);
    directed(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 64'hFFFF_FFFE_0000_0001, 1'b1);
    directed(1'b1, 32'hFFFF_FFFD, 32'd5, 4'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    directed(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd6, 64'h0000_0000_8000_0000, 1'b1);

    // Backpressure: stall the sink, offer three back-to-back.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    drive_op(1'b0, 32'd1, 32'd10, 4'd1);
    @(negedge clk);
    chk("bp_ready1", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 drive_op(1'b0, 32'd2, 32'd10, 4'd2);
    @(negedge clk);
    chk("bp_ready2", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 drive_op(1'b0, 32'd3, 32'd10, 4'd3);
    @(negedge clk);
    chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_full_occ", 64'(occupancy), 64'(P));
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out1_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_out1_tag", 64'(bus.out_tag), 64'd1);
    chk("bp_ready_thru", 64'(bus.in_ready), 64'd1);
    chk("bp_occ_keep", 64'(occupancy), 64'(P));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk("bp_occ_after", 64'(occupancy), 64'(P));
    @(negedge clk);
    chk("bp_out2_tag", 64'(bus.out_tag), 64'd2);
    @(negedge clk);
    chk("bp_out3_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_out3_tag", 64'(bus.out_tag), 64'd3);
    @(negedge clk);
    chk("bp_empty", 64'(bus.out_valid), 64'd0);

    // Flush with the pipe full and an op offered.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(1'b0, 32'd9, 32'd9, 4'd7);
    send(1'b0, 32'd8, 32'd8, 4'd8);
    drive_op(1'b1, 32'd5, 32'd5, 4'd9);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_in_ready", 64'(bus.in_ready), 64'd0);
    chk("fl_occ_before", 64'(occupancy), 64'(P));
    @(posedge clk);
    #1 flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("fl_occ_after", 64'(occupancy), 64'd0);
    chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (P) @(negedge clk);
    chk("fl_no_stale", 64'(bus.out_valid), 64'd0);

    // Reset with two ops in flight.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(1'b0, 32'd11, 32'd11, 4'd10);
    send(1'b0, 32'd12, 32'd12, 4'd11);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_occ", 64'(occupancy), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("mr_out_valid2", 64'(bus.out_valid), 64'd0);
    directed(1'b0, 32'd2, 32'd2, 4'd12, 64'd4, 1'b0);

    // Random stream with random sink readiness.
    pops0 = pops;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic [31:0] a, b;
          a = $urandom;
          b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
          end
          send(1'($urandom_range(0, 1)), a, b, TL'(i));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
    chk("stream_count", 64'(pops - pops0), 64'd100);
    chk("end_occ", 64'(occupancy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
